// File: rtl/stage_mem.sv
// stage_mem: memory stage of the 5-stage core, between execute and stage_wb.
// Runs loads and stores as single Wishbone classic cycles. Store data and byte
// selects are lane-aligned, load data is extracted and sign/zero-extended, and
// misaligned accesses are flagged instead of being issued to the bus.
// Everything lands in the MEM/WB register. Upstream is stalled while a cycle
// is outstanding.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   valid_i, flush_i       live instruction from execute / kill from WB
//   pc_i, instruction_i    passed through to the MEM/WB register
//   funct3_i               access width (bits 1:0) and unsigned flag (bit 2)
//   alu_d_i, rs2_d_i       effective address / store data
//   is_ld_mem_i/is_st_mem_i  load / store decode
//   dwbm_*                 Wishbone data master
//   stall_o                hold execute and earlier stages
//   valid_o .. e_st_addr_mis_o  MEM/WB register outputs
//
// state | meaning
// IDLE  | no bus cycle outstanding; samples the execute outputs every edge
// BUSY  | bus cycle outstanding; inputs held upstream, waiting for ack
module stage_mem (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instruction_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_d_i,
    input  logic [31:0] rs2_d_i,
    input  logic        is_ld_mem_i,
    input  logic        is_st_mem_i,
    output logic [31:0] dwbm_addr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_we_o,
    output logic        dwbm_cyc_o,
    output logic        dwbm_stb_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic [31:0] alu_d_o,
    output logic [31:0] mem_d_o,
    output logic [31:0] mem_addr_o,
    output logic        e_ld_addr_mis_o,
    output logic        e_st_addr_mis_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]  r_state;
    logic        r_flushed;
    logic        r_is_ld;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;

    logic        w_is_mem;
    logic        w_mis;
    logic        w_take;
    logic        w_go_bus;
    logic [3:0]  w_sel;
    logic [31:0] w_dat;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    always_comb begin
        w_is_mem = is_ld_mem_i | is_st_mem_i;
        case (funct3_i[1:0])
            2'b00:   w_mis = 1'b0;
            2'b01:   w_mis = alu_d_i[0];
            default: w_mis = |alu_d_i[1:0];
        endcase
        w_take   = valid_i & ~flush_i;
        w_go_bus = w_take & w_is_mem & ~w_mis;
    end

    // Loads always read the full word; lane selection happens on return.
    always_comb begin
        w_sel = 4'b1111;
        w_dat = rs2_d_i;
        if (is_st_mem_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    w_sel = 4'b0001 << alu_d_i[1:0];
                    w_dat = {4{rs2_d_i[7:0]}};
                end
                2'b01: begin
                    w_sel = alu_d_i[1] ? 4'b1100 : 4'b0011;
                    w_dat = {2{rs2_d_i[15:0]}};
                end
                default: begin
                    w_sel = 4'b1111;
                    w_dat = rs2_d_i;
                end
            endcase
        end
    end

    always_comb begin
        case (r_off)
            2'b00:   w_byte = dwbm_dat_i[7:0];
            2'b01:   w_byte = dwbm_dat_i[15:8];
            2'b10:   w_byte = dwbm_dat_i[23:16];
            default: w_byte = dwbm_dat_i[31:24];
        endcase
        w_half = r_off[1] ? dwbm_dat_i[31:16] : dwbm_dat_i[15:0];
        case (r_funct3[1:0])
            2'b00:   w_ld_data = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
            2'b01:   w_ld_data = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
            default: w_ld_data = dwbm_dat_i;
        endcase
    end

    assign stall_o = (r_state == ST_BUSY) ? ~dwbm_ack_i : w_go_bus;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= ST_IDLE;
            r_flushed       <= 1'b0;
            r_is_ld         <= 1'b0;
            r_funct3        <= 3'd0;
            r_off           <= 2'd0;
            dwbm_addr_o     <= 32'd0;
            dwbm_dat_o      <= 32'd0;
            dwbm_sel_o      <= 4'd0;
            dwbm_we_o       <= 1'b0;
            dwbm_cyc_o      <= 1'b0;
            dwbm_stb_o      <= 1'b0;
            valid_o         <= 1'b0;
            pc_o            <= 32'd0;
            instruction_o   <= 32'd0;
            alu_d_o         <= 32'd0;
            mem_d_o         <= 32'd0;
            mem_addr_o      <= 32'd0;
            e_ld_addr_mis_o <= 1'b0;
            e_st_addr_mis_o <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    pc_o          <= pc_i;
                    instruction_o <= instruction_i;
                    alu_d_o       <= alu_d_i;
                    mem_addr_o    <= alu_d_i;
                    mem_d_o       <= 32'd0;
                    r_funct3      <= funct3_i;
                    r_off         <= alu_d_i[1:0];
                    r_is_ld       <= is_ld_mem_i;
                    r_flushed     <= 1'b0;
                    if (w_go_bus) begin
                        r_state         <= ST_BUSY;
                        dwbm_cyc_o      <= 1'b1;
                        dwbm_stb_o      <= 1'b1;
                        dwbm_addr_o     <= {alu_d_i[31:2], 2'b00};
                        dwbm_we_o       <= is_st_mem_i;
                        dwbm_sel_o      <= w_sel;
                        dwbm_dat_o      <= w_dat;
                        valid_o         <= 1'b0;
                        e_ld_addr_mis_o <= 1'b0;
                        e_st_addr_mis_o <= 1'b0;
                    end else begin
                        valid_o         <= w_take;
                        e_ld_addr_mis_o <= w_take & is_ld_mem_i & w_mis;
                        e_st_addr_mis_o <= w_take & is_st_mem_i & w_mis;
                    end
                end
                ST_BUSY: begin
                    if (dwbm_ack_i) begin
                        r_state    <= ST_IDLE;
                        dwbm_cyc_o <= 1'b0;
                        dwbm_stb_o <= 1'b0;
                        dwbm_we_o  <= 1'b0;
                        dwbm_sel_o <= 4'd0;
                        // A flush arriving on the ack cycle still kills the result.
                        valid_o    <= ~(r_flushed | flush_i);
                        mem_d_o    <= r_is_ld ? w_ld_data : 32'd0;
                        r_flushed  <= 1'b0;
                    end else begin
                        r_flushed  <= r_flushed | flush_i;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
module tb_stage_mem;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] instruction_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] alu_d_i = '0;
    logic [31:0] rs2_d_i = '0;
    logic        is_ld_mem_i = 1'b0;
    logic        is_st_mem_i = 1'b0;
    logic [31:0] dwbm_addr_o, dwbm_dat_o;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_we_o, dwbm_cyc_o, dwbm_stb_o;
    logic [31:0] dwbm_dat_i = '0;
    logic        dwbm_ack_i = 1'b0;
    logic        stall_o, valid_o;
    logic [31:0] pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o;
    logic        e_ld_addr_mis_o, e_st_addr_mis_o;

    always #5 clk = ~clk;

    stage_mem dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
        .pc_i(pc_i), .instruction_i(instruction_i), .funct3_i(funct3_i),
        .alu_d_i(alu_d_i), .rs2_d_i(rs2_d_i),
        .is_ld_mem_i(is_ld_mem_i), .is_st_mem_i(is_st_mem_i),
        .dwbm_addr_o(dwbm_addr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
        .dwbm_we_o(dwbm_we_o), .dwbm_cyc_o(dwbm_cyc_o), .dwbm_stb_o(dwbm_stb_o),
        .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i),
        .stall_o(stall_o), .valid_o(valid_o), .pc_o(pc_o),
        .instruction_o(instruction_o), .alu_d_o(alu_d_o), .mem_d_o(mem_d_o),
        .mem_addr_o(mem_addr_o), .e_ld_addr_mis_o(e_ld_addr_mis_o),
        .e_st_addr_mis_o(e_st_addr_mis_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rules, stated in terms of access size and byte offsets.
    function automatic logic mis_f(input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = 1 << f3[1:0];
        return (int'(a[1:0]) % size) != 0;
    endfunction

    function automatic logic [31:0] ld_f(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * int'(a[1:0]));
        if (f3[1:0] == 2'd0) begin
            v = v & 32'h0000_00FF;
            if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (f3[1:0] == 2'd1) begin
            v = v & 32'h0000_FFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] sel_f(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'd0) return 4'(1 << a[1:0]);
        if (f3[1:0] == 2'd1) return 4'(3 << a[1:0]);
        return 4'hF;
    endfunction

    function automatic logic [31:0] dat_f(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return 32'(d[7:0]) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    logic        chk_en = 1'b0;
    logic        exp_valid = 0, exp_cyc = 0, exp_stall = 0, exp_we = 0, exp_eld = 0, exp_est = 0;
    logic [3:0]  exp_sel = 0;
    logic [31:0] exp_addr = 0, exp_dat = 0, exp_pc = 0, exp_instr = 0, exp_alu = 0;
    logic [31:0] exp_mem_d = 0, exp_mem_addr = 0;
    logic [31:0] cap_addr = 0, cap_dat = 0, cap_mem_d = 0, cap_alu = 0;
    logic [3:0]  cap_sel = 0;
    logic        cap_eld = 0, cap_est = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_o", 32'(valid_o), 32'(exp_valid));
            check("cyc", 32'(dwbm_cyc_o), 32'(exp_cyc));
            check("stb", 32'(dwbm_stb_o), 32'(exp_cyc));
            check("stall", 32'(stall_o), 32'(exp_stall));
            check("e_ld_mis", 32'(e_ld_addr_mis_o), 32'(exp_eld));
            check("e_st_mis", 32'(e_st_addr_mis_o), 32'(exp_est));
            if (exp_cyc) begin
                check("bus_addr", dwbm_addr_o, exp_addr);
                check("bus_sel", 32'(dwbm_sel_o), 32'(exp_sel));
                check("bus_we", 32'(dwbm_we_o), 32'(exp_we));
                if (exp_we) check("bus_dat", dwbm_dat_o, exp_dat);
                cap_addr = dwbm_addr_o;
                cap_sel  = dwbm_sel_o;
                cap_dat  = dwbm_dat_o;
            end
            if (exp_valid) begin
                check("pc_o", pc_o, exp_pc);
                check("instr_o", instruction_o, exp_instr);
                check("alu_d_o", alu_d_o, exp_alu);
                check("mem_addr_o", mem_addr_o, exp_mem_addr);
                check("mem_d_o", mem_d_o, exp_mem_d);
                cap_mem_d = mem_d_o;
                cap_alu   = alu_d_o;
                cap_eld   = e_ld_addr_mis_o;
                cap_est   = e_st_addr_mis_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        exp_stall = 1'b0;
        tick();
        exp_valid = 1'b0;
        exp_eld   = 1'b0;
        exp_est   = 1'b0;
    endtask

    // One instruction through the stage. fl_busy selects the BUSY cycle (1-based)
    // that carries a flush pulse (0 = none); d is the BUSY cycle that gets ack.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2, input logic [31:0] rd,
                         input logic fl_idle, input int fl_busy, input int d);
        logic mis, take, bus, flushed;
        logic [31:0] pc, ins;
        pc  = $urandom;
        ins = $urandom;
        valid_i = 1'b1; flush_i = fl_idle; pc_i = pc; instruction_i = ins;
        funct3_i = f3; alu_d_i = a; rs2_d_i = rs2; is_ld_mem_i = ld; is_st_mem_i = st;
        mis  = (ld || st) && mis_f(f3, a);
        take = !fl_idle;
        bus  = take && (ld || st) && !mis;
        exp_stall = bus;
        tick();
        exp_pc = pc; exp_instr = ins; exp_alu = a; exp_mem_addr = a;
        if (!bus) begin
            exp_cyc   = 1'b0;
            exp_valid = take;
            exp_eld   = take && ld && mis;
            exp_est   = take && st && mis;
            exp_mem_d = 32'd0;
            valid_i = 1'b0; flush_i = 1'b0; exp_stall = 1'b0;
        end else begin
            flush_i   = 1'b0;
            exp_valid = 1'b0; exp_eld = 1'b0; exp_est = 1'b0;
            exp_cyc   = 1'b1;
            exp_we    = st;
            exp_addr  = {a[31:2], 2'b00};
            exp_sel   = st ? sel_f(f3, a) : 4'hF;
            exp_dat   = dat_f(f3, rs2);
            dwbm_dat_i = rd;
            flushed = 1'b0;
            for (int n = 1; n <= d; n++) begin
                flush_i = (n == fl_busy);
                if (flush_i) flushed = 1'b1;
                dwbm_ack_i = (n == d);
                exp_stall  = !dwbm_ack_i;
                tick();
            end
            dwbm_ack_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; exp_stall = 1'b0;
            dwbm_dat_i = $urandom;
            exp_cyc   = 1'b0;
            exp_valid = !flushed;
            exp_mem_d = ld ? ld_f(f3, a, rd) : 32'd0;
        end
    endtask

    initial begin
        logic ld, st, fl_idle;
        logic [2:0] f3;
        int kind, d, fl_busy;

        tick();
        tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_cyc", 32'(dwbm_cyc_o), 32'd0);
        check("rst_sel", 32'(dwbm_sel_o), 32'd0);
        check("rst_we", 32'(dwbm_we_o), 32'd0);
        check("rst_mem_d", mem_d_o, 32'd0);
        check("rst_mis", 32'({e_ld_addr_mis_o, e_st_addr_mis_o}), 32'd0);
        rst_i  = 1'b0;
        chk_en = 1'b1;

        issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 3);
        idle_cycle();
        check("pin_sw_addr", cap_addr, 32'h100);
        check("pin_sw_sel", 32'(cap_sel), 32'hF);
        check("pin_sw_dat", cap_dat, 32'hDEADBEEF);
        check("pin_sw_mem_d", cap_mem_d, 32'h0);

        issue(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 1);
        idle_cycle();
        check("pin_sb_sel", 32'(cap_sel), 32'h8);
        check("pin_sb_dat", cap_dat, 32'hA5A5A5A5);

        issue(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 2);
        idle_cycle();
        check("pin_lb", cap_mem_d, 32'hFFFFFF80);
        issue(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 1);
        idle_cycle();
        check("pin_lbu", cap_mem_d, 32'h00000080);
        issue(1, 0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 0, 1);
        idle_cycle();
        check("pin_lh", cap_mem_d, 32'hFFFF8001);

        issue(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0, 1);
        idle_cycle();
        check("pin_lh_mis", 32'(cap_eld), 32'd1);
        issue(0, 1, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 1);
        idle_cycle();
        check("pin_sw_mis", 32'(cap_est), 32'd1);
        issue(0, 0, 3'b000, 32'h12345678, 32'h0, 32'h0, 0, 0, 1);
        idle_cycle();
        check("pin_add_alu", cap_alu, 32'h12345678);

        // Flush during BUSY: cycle completes, result suppressed, next load clean.
        issue(1, 0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 0, 2, 4);
        issue(1, 0, 3'b010, 32'h304, 32'h0, 32'h13579BDF, 0, 0, 1);
        idle_cycle();
        check("pin_lw_after_flush", cap_mem_d, 32'h13579BDF);

        // Reset while BUSY, ack arrives only after reset.
        valid_i = 1'b1; pc_i = 32'h40; funct3_i = 3'b010; alu_d_i = 32'h200;
        is_ld_mem_i = 1'b1; is_st_mem_i = 1'b0;
        exp_stall = 1'b1;
        tick();
        exp_cyc = 1'b1; exp_we = 1'b0; exp_addr = 32'h200; exp_sel = 4'hF;
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; valid_i = 1'b0; is_ld_mem_i = 1'b0;
        exp_cyc = 1'b0; exp_valid = 1'b0; exp_stall = 1'b0;
        check("rst_busy_sel", 32'(dwbm_sel_o), 32'd0);
        dwbm_ack_i = 1'b1; dwbm_dat_i = 32'h55AA55AA;
        tick();
        dwbm_ack_i = 1'b0;
        tick();
        check("late_ack_mem_d", mem_d_o, 32'd0);

        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 2);
            ld = (kind == 1);
            st = (kind == 2);
            if (ld) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else if (st) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                f3 = 3'($urandom);
            end
            fl_idle = ($urandom_range(0, 9) == 0);
            d       = $urandom_range(1, 4);
            fl_busy = ($urandom_range(0, 5) == 0) ? $urandom_range(1, d) : 0;
            issue(ld, st, f3, $urandom, $urandom, $urandom, fl_idle, fl_busy, d);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stage_mem.md
Name: stage_mem

Overview:
- Memory stage of the 5-stage core. Sits between the execute stage and stage_wb.
- Accepts one instruction per cycle from execute. Runs loads and stores on the Wishbone data master port and aligns store data and byte selects. Extracts and sign- or zero-extends load data.
- Detects load/store address misalignment.
- Registers all results into the MEM/WB pipeline boundary. Stalls upstream while a bus cycle is outstanding.

Parameters:
- none.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  execute output holds a live instruction
- flush_i  in  1  kill the instruction in this stage (exception/xret taken in WB)
- pc_i  in  32  instruction PC
- instruction_i  in  32  instruction word
- funct3_i  in  3  load/store width and sign
- alu_d_i  in  32  ALU result (effective address for ld/st)
- rs2_d_i  in  32  store data
- is_ld_mem_i  in  1  load
- is_st_mem_i  in  1  store
- dwbm_addr_o  out  32  word-aligned bus address
- dwbm_dat_o  out  32  write data
- dwbm_sel_o  out  4  byte lane selects
- dwbm_we_o  out  1  write enable
- dwbm_cyc_o  out  1  bus cycle
- dwbm_stb_o  out  1  strobe
- dwbm_dat_i  in  32  read data
- dwbm_ack_i  in  1  bus acknowledge
- stall_o  out  1  hold execute and earlier stages
- valid_o  out  1  MEM/WB register holds a live instruction
- pc_o  out  32  registered pc_i
- instruction_o  out  32  registered instruction_i
- alu_d_o  out  32  registered alu_d_i
- mem_d_o  out  32  extended load data
- mem_addr_o  out  32  registered effective address
- e_ld_addr_mis_o  out  1  misaligned load
- e_st_addr_mis_o  out  1  misaligned store

Behaviour:
- Reset (synchronous, rst_i high at a clk_i edge): FSM goes to IDLE. All outputs are 0, including cyc/stb/we/sel, valid_o, the error flags and mem_d_o. Reset mid-bus-cycle drops cyc/stb on the same edge; a late ack is ignored.
- FSM states are IDLE and BUSY.
- Misalignment:
  - LH, LHU, SH: misaligned when addr[0] is 1.
  - LW, SW: misaligned when addr[1:0] is not 0.
  - LB, LBU, SB: never misaligned.
- IDLE, valid_i && !flush_i:
  - Non-memory instruction or misaligned ld/st: no bus cycle. The MEM/WB register loads next edge with valid_o=1 and mem_d_o=0. The matching e_*_mis_o is set. stall_o=0. Latency 1 cycle.
  - Aligned ld/st: on the next edge, register bus outputs and enter BUSY with cyc=stb=1. dwbm_addr_o = {alu_d_i[31:2],2'b00}, dwbm_we_o = is_st_mem_i. stall_o=1 combinationally in this cycle; valid_o loads 0.
- Store lane formatting:
  - SB: sel = 4'b0001 << addr[1:0], data = rs2[7:0] replicated x4.
  - SH: sel = addr[1] ? 4'b1100 : 4'b0011, data = rs2[15:0] replicated x2.
  - SW: sel = 4'b1111, data = rs2.
- Loads drive sel=4'b1111.
- BUSY:
  - cyc/stb and all bus outputs stay stable until ack. stall_o = !dwbm_ack_i.
  - On ack, on the same edge: cyc=stb=0, go to IDLE, valid_o=1, and mem_d_o is loaded.
  - Load extraction uses the registered addr[1:0]. LB/LBU take the selected byte with sign/zero extension. LH/LHU take the half selected by addr[1] with sign/zero extension. LW takes the full word. Stores load mem_d_o=0.
  - Minimum load-to-WB latency is 2 cycles (ack in first BUSY cycle). There is no upper bound; the block waits for ack forever.
- flush_i:
  - In IDLE: the instruction is dropped (valid_o=0) and no bus cycle starts.
  - In BUSY: the bus cycle cannot be aborted. It completes on ack, but valid_o stays 0 on completion. The flush is latched internally until then.
- valid_i=0 in IDLE: valid_o=0 next edge and error flags are 0.
- While stall_o=1, upstream holds its inputs constant; the block samples only at the IDLE start edge.
- Back-to-back memory ops: the cycle after the ack edge is IDLE and may start the next request. There is one idle bus cycle between transactions.
- Error flags are 1-cycle registered, aligned with valid_o. They are never set together with a bus cycle.

Test Plan:
- SW addr 0x100, rs2 0xDEADBEEF, ack after 3 cycles → cyc/stb high for 3 cycles, addr 0x100, sel 1111, we=1, stall_o high until the ack cycle, valid_o=1 next edge, mem_d_o=0.
- SB addr 0x103, rs2 0x000000A5 → sel 1000, dat 0xA5A5A5A5. LB 0x103 with bus data 0x80FF0000 → mem_d_o 0xFFFFFF80. LBU gives 0x00000080.
- LH addr 0x102, bus data 0x8001xxxx → mem_d_o 0xFFFF8001. LH addr 0x101 → no cyc, e_ld_addr_mis_o=1, valid_o=1, stall_o=0.
- SW addr 0x102 → e_st_addr_mis_o=1, cyc stays 0. ADD instruction → valid_o=1 one cycle later, alu_d_o passed through, stall_o=0.
- LW issued, flush_i pulsed in the second BUSY cycle, ack in the fourth → bus cycle completes, valid_o stays 0. A following LW starts cleanly.
- rst_i asserted mid-BUSY, ack arriving after reset → cyc/stb 0 after the reset edge, valid_o 0, the late ack produces no output.
